// File: rtl/shift_seq_ctrl_pkg.sv
// Shared opcode constants and sequencer state encoding for the shift-register block.
// Pure definitions: no latency, no flow control.
package shift_seq_ctrl_pkg;

    localparam logic [2:0] OP_CLR  = 3'b000;
    localparam logic [2:0] OP_SET1 = 3'b001;
    localparam logic [2:0] OP_SRL  = 3'b010;
    localparam logic [2:0] OP_SLL  = 3'b011;
    localparam logic [2:0] OP_SRA  = 3'b100;
    localparam logic [2:0] OP_SIN  = 3'b101;
    localparam logic [2:0] OP_ROR  = 3'b110;
    localparam logic [2:0] OP_ROL  = 3'b111;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ONESHOT = 2'd1,
        RUN     = 2'd2,
        FIN     = 2'd3
    } state_t;

    // clr/set1 act once and ignore the step count
    function automatic logic is_oneshot(input logic [2:0] op);
        return (op == OP_CLR) || (op == OP_SET1);
    endfunction

endpackage

// File: rtl/shift_tick_div.sv
// Step-rate divider: free-runs 0..TICK_DIV-1 while en, tc high in the terminal cycle.
// tc is combinational from the count; clr wins over en; no backpressure.
module shift_tick_div #(
    parameter int TICK_DIV = 10000000,
    parameter int DIV_W    = 24
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [DIV_W-1:0] LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] cnt;

    assign tc = en && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Command sequencer driving the 8-bit shift datapath; one command in flight, first step
// TICK_DIV cycles after accept (clr/set1: next cycle); cmd_ready low until back in IDLE.
module shift_seq_ctrl
    import shift_seq_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 10000000,
    parameter int CNT_W    = 8,
    parameter int DIV_W    = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic [7:0]       cmd_data,
    input  logic             abort,
    output logic [2:0]       sh_ctrl,
    output logic             sh_en,
    output logic             sh_din,
    output logic             busy,
    output logic             done
);

    state_t           state;
    logic [2:0]       op_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] step_q;
    logic [CNT_W-1:0] step_nxt;
    logic [7:0]       data_q;
    logic [2:0]       bit_idx;
    logic             accept;
    logic             run_en;
    logic             tick_tc;
    logic             fire;
    logic             last_step;

    assign accept    = cmd_valid && cmd_ready;
    assign run_en    = (state == RUN);
    assign step_nxt  = step_q + CNT_W'(1);
    assign last_step = (cnt_q != '0) && (step_nxt == cnt_q);

    shift_tick_div #(
        .TICK_DIV (TICK_DIV),
        .DIV_W    (DIV_W)
    ) u_tick_div (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .en    (run_en),
        .tc    (tick_tc)
    );

    // abort suppresses a strobe in the very cycle it is seen
    assign fire    = !abort && ((state == ONESHOT) || (run_en && tick_tc));
    assign sh_en   = fire;
    assign sh_ctrl = op_q;
    assign sh_din  = (op_q == OP_SIN) ? data_q[bit_idx] : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_q      <= OP_CLR;
            cnt_q     <= '0;
            data_q    <= '0;
            step_q    <= '0;
            bit_idx   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cmd_ready <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q      <= cmd_op;
                        cnt_q     <= cmd_cnt;
                        data_q    <= cmd_data;
                        step_q    <= '0;
                        bit_idx   <= '0;
                        busy      <= 1'b1;
                        cmd_ready <= 1'b0;
                        state     <= is_oneshot(cmd_op) ? ONESHOT : RUN;
                    end
                end
                ONESHOT: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= FIN;
                end
                RUN: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FIN;
                    end else if (fire) begin
                        // continuous mode (cnt=0) lets the step counter wrap
                        step_q  <= step_nxt;
                        bit_idx <= bit_idx + 3'd1;
                        if (last_step) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= FIN;
                        end
                    end
                end
                FIN: begin
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl with TICK_DIV=4 and a small datapath model.
// Cycle 0 is the accept cycle; cycle c is observed mid-period after the c-th following edge.
module tb_shift_seq_ctrl;

    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [CNT_W-1:0] cmd_cnt;
    logic [7:0]       cmd_data;
    logic             abort;
    logic [2:0]       sh_ctrl;
    logic             sh_en;
    logic             sh_din;
    logic             busy;
    logic             done;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] en_mask;
    logic [63:0] done_mask;
    logic [63:0] ready_mask;
    logic [15:0] din_seq;
    logic [2:0]  ctrl_log [0:63];
    logic [7:0]  dp;
    logic        dp_load;

    shift_seq_ctrl #(
        .TICK_DIV (4),
        .CNT_W    (CNT_W),
        .DIV_W    (24)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_cnt   (cmd_cnt),
        .cmd_data  (cmd_data),
        .abort     (abort),
        .sh_ctrl   (sh_ctrl),
        .sh_en     (sh_en),
        .sh_din    (sh_din),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference datapath: applies the opcode on each strobe
    always @(posedge clk) begin
        if (dp_load) dp <= 8'h80;
        else if (sh_en) begin
            case (sh_ctrl)
                3'b000: dp <= 8'h00;
                3'b001: dp <= 8'h01;
                3'b010: dp <= {1'b0, dp[7:1]};
                3'b011: dp <= {dp[6:0], 1'b0};
                3'b100: dp <= {dp[7], dp[7:1]};
                3'b101: dp <= {sh_din, dp[7:1]};
                3'b110: dp <= {dp[0], dp[7:1]};
                default: dp <= {dp[6:0], dp[7]};
            endcase
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic start(input logic [2:0] op, input logic [CNT_W-1:0] cnt, input logic [7:0] data);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_cnt   = cnt;
        cmd_data  = data;
        dp_load   = 1'b1;
        #1;
        chk("accept_ready", {63'd0, cmd_ready}, 64'd1);
    endtask

    task automatic run(input int n, input int abort_at, input int drop_at,
                       input logic [2:0] op2, input logic [CNT_W-1:0] cnt2);
        int k;
        k          = 0;
        en_mask    = '0;
        done_mask  = '0;
        ready_mask = '0;
        din_seq    = '0;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            dp_load = 1'b0;
            if (c == 1) begin
                cmd_op  = op2;
                cmd_cnt = cnt2;
            end
            if (c == drop_at) cmd_valid = 1'b0;
            abort = (c == abort_at);
            #1;
            if (sh_en) begin
                en_mask[c] = 1'b1;
                if (k < 16) din_seq[k] = sh_din;
                k++;
            end
            if (done)      done_mask[c]  = 1'b1;
            if (cmd_ready) ready_mask[c] = 1'b1;
            ctrl_log[c] = sh_ctrl;
        end
        abort = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'b000;
        cmd_cnt   = '0;
        cmd_data  = 8'h00;
        abort     = 1'b0;
        dp_load   = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        chk("reset_outputs", {56'd0, sh_ctrl, sh_en, sh_din, busy, done, cmd_ready}, 64'h01);
        @(negedge clk);
        rst_n = 1'b1;

        // srl, 3 steps: strobes at 4/8/12, done at 13, ready again at 14
        start(3'b010, 8'd3, 8'h00);
        run(15, 0, 1, 3'b010, 8'd3);
        chk("srl_en", en_mask, 64'h1110);
        chk("srl_done", done_mask, 64'h2000);
        chk("srl_ready", ready_mask, 64'hC000);
        chk("srl_ctrl", {61'd0, ctrl_log[4]}, 64'h2);
        chk("srl_dp", {56'd0, dp}, 64'h10);

        // set1 with cnt=5: single strobe next cycle, count ignored
        start(3'b001, 8'd5, 8'h00);
        run(4, 0, 1, 3'b001, 8'd5);
        chk("set1_en", en_mask, 64'h2);
        chk("set1_done", done_mask, 64'h4);
        chk("set1_ready", ready_mask, 64'h18);
        chk("set1_dp", {56'd0, dp}, 64'h01);

        // serial-in 10 steps of 0xA5, index wraps so steps 9/10 reuse bits 0/1
        start(3'b101, 8'd10, 8'hA5);
        run(45, 0, 1, 3'b101, 8'd10);
        chk("sin_pulses", 64'($countones(en_mask)), 64'd10);
        chk("sin_bits", {54'd0, din_seq[9:0]}, 64'h1A5);
        chk("sin_done", done_mask, 64'd1 << 41);

        // continuous ror aborted at cycle 14
        start(3'b110, 8'd0, 8'h00);
        run(17, 14, 1, 3'b110, 8'd0);
        chk("ror_en", en_mask, 64'h1110);
        chk("ror_done", done_mask, 64'h8000);
        chk("ror_ctrl", {61'd0, ctrl_log[12]}, 64'h6);

        // abort coincident with terminal count suppresses that strobe
        start(3'b110, 8'd0, 8'h00);
        run(10, 8, 1, 3'b110, 8'd0);
        chk("abort_tc_en", en_mask, 64'h10);
        chk("abort_tc_done", done_mask, 64'h200);

        // abort during the one-shot cycle
        start(3'b000, 8'd0, 8'h00);
        run(4, 1, 1, 3'b000, 8'd0);
        chk("abort_os_en", en_mask, 64'h0);
        chk("abort_os_done", done_mask, 64'h4);

        // second command held off until IDLE (offered during FIN too)
        start(3'b010, 8'd1, 8'h00);
        run(13, 0, 7, 3'b011, 8'd1);
        chk("hold_en", en_mask, 64'h410);
        chk("hold_done", done_mask, 64'h820);
        chk("hold_ready", ready_mask, 64'h3040);
        chk("hold_ctrl_first", {61'd0, ctrl_log[5]}, 64'h2);
        chk("hold_ctrl_second", {61'd0, ctrl_log[10]}, 64'h3);

        // abort in IDLE is ignored
        run(3, 1, 1, 3'b000, 8'd0);
        chk("idle_abort_done", done_mask, 64'h0);
        chk("idle_abort_ready", ready_mask, 64'hE);

        // reset while a strobe is active drops everything at once
        start(3'b010, 8'd0, 8'h00);
        run(4, 0, 1, 3'b010, 8'd0);
        chk("prereset_en", en_mask, 64'h10);
        rst_n = 1'b0;
        #1;
        chk("midrun_reset", {59'd0, sh_ctrl == 3'b000, sh_en, busy, done, cmd_ready}, 64'h11);
        @(negedge clk);
        rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
